alu_exec_ctrl: RTL

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/alu_exec_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// Sequencing controller for an external combinational ALU: snapshots operands from a
// small register file, drives the ALU for two cycles, then writes the result back.
module alu_exec_ctrl #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumOpCodeBits = 5,
  parameter int unsigned ParamBits     = 8,
  parameter int unsigned NumStatusBits = 4,
  parameter int unsigned NumRegs       = 4,
  localparam int unsigned AW = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NumOpCodeBits-1:0] req_opcode,
  input  logic [AW-1:0]            req_src1,
  input  logic [AW-1:0]            req_src2,
  input  logic [AW-1:0]            req_dst,
  input  logic [ParamBits-1:0]     req_param,
  input  logic                     ld_en,
  input  logic [AW-1:0]            ld_addr,
  input  logic [DataWidth-1:0]     ld_data,
  input  logic [AW-1:0]            rd_addr,
  output logic [DataWidth-1:0]     rd_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic                     done,
  output logic                     err,
  output logic [NumStatusBits-1:0] flags
);

  localparam int unsigned MaxLegalOp = 9;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [NumOpCodeBits-1:0] op_q, op_d;
  logic [ParamBits-1:0]     param_q, param_d;
  logic [AW-1:0]            dst_q, dst_d;
  logic [DataWidth-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [DataWidth-1:0]     regs_q [NumRegs];
  logic [DataWidth-1:0]     regs_d [NumRegs];
  logic [NumStatusBits-1:0] flags_q, flags_d;
  logic                     done_q, done_d, err_q, err_d;
  logic [NumOpCodeBits-1:0] alu_opcode_q, alu_opcode_d;
  logic [DataWidth-1:0]     alu_operand1_q, alu_operand1_d;
  logic [DataWidth-1:0]     alu_operand2_q, alu_operand2_d;
  logic [ParamBits-1:0]     alu_param_q, alu_param_d;
  logic                     op_illegal_c, op_exec_c;

  // Illegal opcodes and NOP both run the full sequence but never write back.
  assign op_illegal_c = 32'(op_q) > MaxLegalOp;
  assign op_exec_c    = !op_illegal_c && (op_q != '0);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    param_d        = param_q;
    dst_d          = dst_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    regs_d         = regs_q;
    flags_d        = flags_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    alu_opcode_d   = '0;
    alu_operand1_d = '0;
    alu_operand2_d = '0;
    alu_param_d    = '0;

    // External load first so a same-address write-back below overrides it.
    if (ld_en) regs_d[ld_addr] = ld_data;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_opcode;
          param_d = req_param;
          dst_d   = req_dst;
          opa_d   = regs_q[req_src1];
          opb_d   = regs_q[req_src2];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        if (op_exec_c) begin
          regs_d[dst_q] = alu_result;
          flags_d       = alu_status;
        end
        done_d  = 1'b1;
        err_d   = op_illegal_c;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // ALU ports are registered so they are valid for the whole ISSUE/CAPTURE window.
    if (state_d == ISSUE || state_d == CAPTURE) begin
      alu_opcode_d   = op_d;
      alu_operand1_d = opa_d;
      alu_operand2_d = opb_d;
      alu_param_d    = param_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= '0;
      param_q        <= '0;
      dst_q          <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      regs_q         <= '{default: '0};
      flags_q        <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      alu_opcode_q   <= '0;
      alu_operand1_q <= '0;
      alu_operand2_q <= '0;
      alu_param_q    <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      param_q        <= param_d;
      dst_q          <= dst_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      regs_q         <= regs_d;
      flags_q        <= flags_d;
      done_q         <= done_d;
      err_q          <= err_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_operand1_q <= alu_operand1_d;
      alu_operand2_q <= alu_operand2_d;
      alu_param_q    <= alu_param_d;
    end
  end

  assign req_ready    = (state_q == IDLE) && !rst;
  assign rd_data      = regs_q[rd_addr];
  assign alu_opcode   = alu_opcode_q;
  assign alu_operand1 = alu_operand1_q;
  assign alu_operand2 = alu_operand2_q;
  assign alu_param    = alu_param_q;
  assign done         = done_q;
  assign err          = err_q;
  assign flags        = flags_q;

endmodule
